// File: rtl/jtlabrun_pkg.sv
// Shared definitions for the Labyrinth Runner graphics ROM arbiter.
//   state_e      : arbiter FSM states
//   gnt_e        : which fetcher owns the SDRAM slot
//   TIMEOUT_FILL : data returned to a fetcher whose access was abandoned
//   pick_grant   : tie-break / round-robin grant selection used in IDLE
package jtlabrun_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_TILE = 1'b0,
    GNT_OBJ  = 1'b1
  } gnt_e;

  localparam logic [15:0] TIMEOUT_FILL = 16'hFFFF;

  // Only meaningful when at least one request is present.
  // Ties: objects win during blanking, otherwise the reset preference applies
  // until somebody has been served, after which it is strict round-robin.
  function automatic gnt_e pick_grant(input logic tile_req, input logic obj_req,
                                      input logic lhbl, input logic has_hist,
                                      input gnt_e last, input logic obj_first);
    gnt_e g;
    if (tile_req && !obj_req)  g = GNT_TILE;
    else if (!tile_req)        g = GNT_OBJ;
    else if (!lhbl)            g = GNT_OBJ;
    else if (!has_hist)        g = obj_first ? GNT_OBJ : GNT_TILE;
    else                       g = (last == GNT_TILE) ? GNT_OBJ : GNT_TILE;
    return g;
  endfunction

endpackage

// File: rtl/jtlabrun_romarb_wdog.sv
// Watchdog counter for the ROM arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   run_i        : count this cycle (arbiter waiting for rom_ok)
//   clr_i        : clear the count (has priority over run_i)
//   expired_o    : the count reaches TIMEOUT on this cycle's increment
// The count saturates at TIMEOUT so a stuck slot never wraps back to "fresh".
module jtlabrun_romarb_wdog #(
  parameter int TIMEOUT = 63
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (run_i && cnt_q != LIMIT) cnt_d = cnt_q + CW'(1);
  end

  // Flag on the cycle the count arrives at TIMEOUT, so the abort happens
  // after exactly TIMEOUT waiting cycles.
  assign expired_o = run_i && !clr_i && (cnt_d == LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jtlabrun_gfx_romarb.sv
// Graphics ROM arbiter: shares one SDRAM slot between the tile and object
// fetchers, with round-robin fairness, a post-grant guard cycle and a watchdog.
//   clk_i, rst_i          : 48 MHz clock, synchronous active-high reset
//   lhbl_i                : horizontal blank (low = blanking, objects win ties)
//   tile_req_i/addr_i     : tile fetch request/address, held until tile_ok_o
//   tile_data_o/ok_o      : tile data and one-cycle valid pulse
//   obj_req_i/addr_i      : object fetch request/address, held until obj_ok_o
//   obj_data_o/ok_o       : object data and one-cycle valid pulse
//   rom_addr_o/cs_o       : SDRAM slot address and request
//   rom_obj_sel_o         : current grant is the object fetcher
//   rom_data_i/ok_i       : SDRAM data and level valid for current rom_addr_o
//   timeout_o             : sticky, some access was abandoned by the watchdog
module jtlabrun_gfx_romarb
  import jtlabrun_pkg::*;
#(
  parameter int AW        = 17,
  parameter int TIMEOUT   = 63,
  parameter bit OBJ_FIRST = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          lhbl_i,
  input  logic          tile_req_i,
  input  logic [AW-1:0] tile_addr_i,
  output logic [15:0]   tile_data_o,
  output logic          tile_ok_o,
  input  logic          obj_req_i,
  input  logic [AW-1:0] obj_addr_i,
  output logic [15:0]   obj_data_o,
  output logic          obj_ok_o,
  output logic [AW-1:0] rom_addr_o,
  output logic          rom_cs_o,
  output logic          rom_obj_sel_o,
  input  logic [15:0]   rom_data_i,
  input  logic          rom_ok_i,
  output logic          timeout_o
);

  state_e        state_q;
  gnt_e          last_q;
  logic          hist_q;
  logic          rom_cs_q, rom_obj_sel_q, tile_ok_q, obj_ok_q, timeout_q;
  logic [AW-1:0] rom_addr_q;
  logic [15:0]   tile_data_q, obj_data_q;

  gnt_e          gnt_new;
  logic          gnt_req, wd_expired;
  logic [15:0]   fetch_data;

  assign gnt_new    = pick_grant(tile_req_i, obj_req_i, lhbl_i, hist_q, last_q, OBJ_FIRST);
  assign gnt_req    = rom_obj_sel_q ? obj_req_i : tile_req_i;
  assign fetch_data = rom_ok_i ? rom_data_i : TIMEOUT_FILL;

  jtlabrun_romarb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (state_q == WAIT),
    .clr_i    (state_q == GUARD),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      last_q        <= GNT_TILE;
      hist_q        <= 1'b0;
      rom_cs_q      <= 1'b0;
      rom_obj_sel_q <= 1'b0;
      rom_addr_q    <= '0;
      tile_ok_q     <= 1'b0;
      obj_ok_q      <= 1'b0;
      tile_data_q   <= '0;
      obj_data_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      tile_ok_q <= 1'b0;
      obj_ok_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tile_req_i || obj_req_i) begin
            rom_obj_sel_q <= (gnt_new == GNT_OBJ);
            rom_addr_q    <= (gnt_new == GNT_OBJ) ? obj_addr_i : tile_addr_i;
            rom_cs_q      <= 1'b1;
            state_q       <= GUARD;
          end
        end
        // rom_ok may still refer to the previous address here, so only the
        // abort path is looked at.
        GUARD: begin
          if (!gnt_req) begin
            rom_cs_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (!gnt_req) begin
            rom_cs_q <= 1'b0;
            state_q  <= IDLE;
          end else if (rom_ok_i || wd_expired) begin
            if (rom_obj_sel_q) begin
              obj_data_q  <= fetch_data;
              obj_ok_q    <= 1'b1;
            end else begin
              tile_data_q <= fetch_data;
              tile_ok_q   <= 1'b1;
            end
            if (!rom_ok_i) timeout_q <= 1'b1;
            last_q   <= rom_obj_sel_q ? GNT_OBJ : GNT_TILE;
            hist_q   <= 1'b1;
            rom_cs_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          rom_cs_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign tile_data_o   = tile_data_q;
  assign tile_ok_o     = tile_ok_q;
  assign obj_data_o    = obj_data_q;
  assign obj_ok_o      = obj_ok_q;
  assign rom_addr_o    = rom_addr_q;
  assign rom_cs_o      = rom_cs_q;
  assign rom_obj_sel_o = rom_obj_sel_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_jtlabrun_gfx_romarb.sv
// Self-checking bench for jtlabrun_gfx_romarb.
module tb_jtlabrun_gfx_romarb;

  localparam int AW      = 17;
  localparam int TIMEOUT = 63;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          lhbl_i = 1'b1;
  logic          tile_req_i = 1'b0, obj_req_i = 1'b0, rom_ok_i = 1'b0;
  logic [AW-1:0] tile_addr_i = '0, obj_addr_i = '0;
  logic [15:0]   rom_data_i = '0;
  logic [15:0]   tile_data_o, obj_data_o;
  logic          tile_ok_o, obj_ok_o, rom_cs_o, rom_obj_sel_o, timeout_o;
  logic [AW-1:0] rom_addr_o;

  jtlabrun_gfx_romarb #(.AW(AW), .TIMEOUT(TIMEOUT), .OBJ_FIRST(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lhbl_i(lhbl_i),
    .tile_req_i(tile_req_i), .tile_addr_i(tile_addr_i),
    .tile_data_o(tile_data_o), .tile_ok_o(tile_ok_o),
    .obj_req_i(obj_req_i), .obj_addr_i(obj_addr_i),
    .obj_data_o(obj_data_o), .obj_ok_o(obj_ok_o),
    .rom_addr_o(rom_addr_o), .rom_cs_o(rom_cs_o), .rom_obj_sel_o(rom_obj_sel_o),
    .rom_data_i(rom_data_i), .rom_ok_i(rom_ok_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_obj;
    logic [15:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic          is_obj;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            lat;      // cycles after grant before rom_ok is raised
    int            exp_lat;  // grant edge to ok edge
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Every ok pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!rst_i && (tile_ok_o || obj_ok_o)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ok: got tile_ok=%0b obj_ok=%0b required none", tile_ok_o, obj_ok_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ok_who", {30'd0, obj_ok_o, tile_ok_o}, e.is_obj ? 32'd2 : 32'd1);
        check("ok_data", e.is_obj ? obj_data_o : tile_data_o, e.data);
      end
    end
  end

  task automatic wait_cs();
    int cyc;
    cyc = 0;
    while (rom_cs_o !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("wait_cs", rom_cs_o, 1);
  endtask

  task automatic wait_ok(input logic is_obj, input int limit, output int cyc);
    cyc = 0;
    while (!(is_obj ? obj_ok_o : tile_ok_o) && cyc < limit) begin
      tick();
      cyc++;
    end
    check("wait_ok", is_obj ? obj_ok_o : tile_ok_o, 1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tile_req_i = 1'b0; obj_req_i = 1'b0; rom_ok_i = 1'b0; lhbl_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
    tick();
  endtask

  task automatic run_one(input vec_t v);
    int cyc;
    lhbl_i = 1'b1;
    if (v.is_obj) begin obj_req_i = 1'b1; obj_addr_i = v.addr; end
    else begin tile_req_i = 1'b1; tile_addr_i = v.addr; end
    sb_q.push_back('{v.is_obj, v.data});
    tick();
    check("grant_cs", rom_cs_o, 1);
    check("grant_addr", rom_addr_o, v.addr);
    check("grant_sel", rom_obj_sel_o, v.is_obj);
    tick(v.lat);
    rom_ok_i = 1'b1;
    rom_data_i = v.data;
    wait_ok(v.is_obj, 100, cyc);
    check("ok_latency", v.lat + cyc, v.exp_lat);
    tile_req_i = 1'b0; obj_req_i = 1'b0; rom_ok_i = 1'b0; rom_data_i = 16'hDEAD;
    check("cs_drop", rom_cs_o, 0);
    tick();
    check("data_hold", v.is_obj ? obj_data_o : tile_data_o, v.data);
    check("idle_after", rom_cs_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 17'h00123, 16'hA5A5, 4, 5};
    vecs[1] = '{1'b1, 17'h1ABCD, 16'h5A5A, 1, 2};
    vecs[2] = '{1'b0, 17'h1FFFF, 16'h0001, 0, 2};
    vecs[3] = '{1'b1, 17'h00000, 16'hFFFE, 7, 8};
    vecs[4] = '{1'b1, 17'h00000, 16'h7E57, 0, 2};  // same requester and address again
    vecs[5] = '{1'b0, 17'h0A5A5, 16'hC3C3, 2, 3};

    tick(3);
    check("rst_cs", rom_cs_o, 0);
    check("rst_addr", rom_addr_o, 0);
    check("rst_sel", rom_obj_sel_o, 0);
    check("rst_tile_ok", tile_ok_o, 0);
    check("rst_obj_ok", obj_ok_o, 0);
    check("rst_tile_data", tile_data_o, 0);
    check("rst_obj_data", obj_data_o, 0);
    check("rst_timeout", timeout_o, 0);
    rst_i = 1'b0;
    tick();
    check("idle_no_req", rom_cs_o, 0);

    for (int i = 0; i < 6; i++) run_one(vecs[i]);
    check("hold_obj_data", obj_data_o, 16'h7E57);
    check("hold_tile_data", tile_data_o, 16'hC3C3);

    // Simultaneous requests straight after reset: tile first, then object.
    do_reset();
    tile_addr_i = 17'h01000; obj_addr_i = 17'h1F0F0;
    tile_req_i = 1'b1; obj_req_i = 1'b1;
    sb_q.push_back('{1'b0, 16'h1111});
    sb_q.push_back('{1'b1, 16'h2222});
    tick();
    check("tie_sel0", rom_obj_sel_o, 0);
    check("tie_addr0", rom_addr_o, 17'h01000);
    begin
      int cyc;
      rom_ok_i = 1'b1; rom_data_i = 16'h1111;
      wait_ok(1'b0, 10, cyc);
      tile_req_i = 1'b0; rom_ok_i = 1'b0;
      wait_cs();
      check("tie_sel1", rom_obj_sel_o, 1);
      check("tie_addr1", rom_addr_o, 17'h1F0F0);
      rom_ok_i = 1'b1; rom_data_i = 16'h2222;
      wait_ok(1'b1, 10, cyc);
      obj_req_i = 1'b0; rom_ok_i = 1'b0;
      tick(2);
      check("tie_sb_empty", sb_q.size(), 0);
    end

    // rom_ok held high across a grant change; last served was object.
    tile_addr_i = 17'h00040; obj_addr_i = 17'h00080;
    tile_req_i = 1'b1; obj_req_i = 1'b1; rom_ok_i = 1'b1; rom_data_i = 16'h3333;
    sb_q.push_back('{1'b0, 16'h3333});
    sb_q.push_back('{1'b1, 16'h4444});
    tick();
    check("rr_sel_tile", rom_obj_sel_o, 0);
    tick();
    check("stale_guard_tile", tile_ok_o, 0);
    tick();
    check("stale_tile_ok", tile_ok_o, 1);
    tile_req_i = 1'b0; rom_data_i = 16'h4444;
    tick();
    check("stale_sel_obj", rom_obj_sel_o, 1);
    check("stale_addr_obj", rom_addr_o, 17'h00080);
    tick();
    check("stale_guard_obj", obj_ok_o, 0);
    tick();
    check("stale_obj_ok", obj_ok_o, 1);
    obj_req_i = 1'b0; rom_ok_i = 1'b0;
    tick();

    // Blanking tie after reset goes to the object; dropping it in GUARD aborts.
    do_reset();
    lhbl_i = 1'b0; tile_req_i = 1'b1; obj_req_i = 1'b1;
    tick();
    check("lhbl_tie_sel", rom_obj_sel_o, 1);
    tile_req_i = 1'b0; obj_req_i = 1'b0; lhbl_i = 1'b1;
    tick();
    check("guard_abort_cs", rom_cs_o, 0);
    tick(2);

    // Abort in WAIT with rom_ok arriving in the same cycle.
    obj_addr_i = 17'h12345; obj_req_i = 1'b1;
    tick(2);
    check("abort_wait_cs", rom_cs_o, 1);
    obj_req_i = 1'b0; rom_ok_i = 1'b1; rom_data_i = 16'hBEEF;
    tick();
    check("abort_cs", rom_cs_o, 0);
    check("abort_obj_ok", obj_ok_o, 0);
    rom_ok_i = 1'b0;
    tick(3);
    check("abort_idle", rom_cs_o, 0);
    check("abort_obj_data", obj_data_o, 0);

    // Watchdog: GUARD plus TIMEOUT waiting cycles, then filled data.
    tile_addr_i = 17'h0F00F; tile_req_i = 1'b1;
    sb_q.push_back('{1'b0, 16'hFFFF});
    tick();
    check("to_grant", rom_cs_o, 1);
    tick(TIMEOUT);
    check("to_early_ok", tile_ok_o, 0);
    check("to_early_flag", timeout_o, 0);
    tick();
    check("to_ok", tile_ok_o, 1);
    check("to_flag", timeout_o, 1);
    check("to_cs", rom_cs_o, 0);
    tile_req_i = 1'b0;
    tick();
    run_one(vecs[1]);
    check("to_sticky", timeout_o, 1);

    // Reset in the middle of an access.
    tile_addr_i = 17'h00777; tile_req_i = 1'b1;
    tick(2);
    check("mid_wait_cs", rom_cs_o, 1);
    rst_i = 1'b1;
    tick();
    check("mid_rst_cs", rom_cs_o, 0);
    check("mid_rst_tile_ok", tile_ok_o, 0);
    check("mid_rst_obj_ok", obj_ok_o, 0);
    check("mid_rst_timeout", timeout_o, 0);
    check("mid_rst_addr", rom_addr_o, 0);
    check("mid_rst_obj_data", obj_data_o, 0);
    rst_i = 1'b0; tile_req_i = 1'b0; rom_ok_i = 1'b1; rom_data_i = 16'h0BAD;
    tick(5);
    check("post_rst_cs", rom_cs_o, 0);
    check("post_rst_tile_data", tile_data_o, 0);
    rom_ok_i = 1'b0;
    tick(2);

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtlabrun_gfx_romarb.md
Name: jtlabrun_gfx_romarb

Overview:
- Shares the single graphics ROM SDRAM port between two fetchers of the video pipeline: the tile/scroll fetcher and the object (sprite) fetcher.
- Sits between the graphics engine and the SDRAM slot that supplies the 17-bit gfx address / 16-bit gfx data bus.
- Produces the ROM chip-select and the object/tile select flag, and returns data plus a per-requester ok.
- Enforces fairness and a watchdog, so that neither fetcher can stall the line buffer indefinitely.

Parameters:
- AW, 17, ROM word-address width.
- TIMEOUT, 63, cycles of clk to wait for rom_ok before the request is aborted.
- OBJ_FIRST, 0, requester granted when both requests are first seen in the same cycle (0=tile, 1=object).

Ports:
- clk  in  1  system clock, 48 MHz.
- rst  in  1  synchronous reset, active high.
- lhbl  in  1  horizontal blank, active low; while low, object requests win ties.
- tile_req  in  1  tile fetch request; held until tile_ok.
- tile_addr  in  AW  tile ROM address; stable while tile_req is high.
- tile_data  out  16  ROM data for the tile fetcher.
- tile_ok  out  1  one-cycle pulse: tile_data is valid for tile_addr.
- obj_req  in  1  object fetch request; held until obj_ok.
- obj_addr  in  AW  object ROM address.
- obj_data  out  16  ROM data for the object fetcher.
- obj_ok  out  1  one-cycle pulse: obj_data is valid.
- rom_addr  out  AW  address to the SDRAM slot.
- rom_cs  out  1  SDRAM request.
- rom_obj_sel  out  1  1 when the current grant is the object fetcher.
- rom_data  in  16  SDRAM data.
- rom_ok  in  1  SDRAM data valid for the current rom_addr (level signal).
- timeout  out  1  sticky flag, set when any access times out; cleared only by rst.

Behaviour:
- Reset values: rom_cs=0, rom_addr=0, rom_obj_sel=0, tile_ok=0, obj_ok=0, tile_data=0, obj_data=0, timeout=0, state=IDLE, last-served=tile.
- Idle state (IDLE):
  - No request: stay in IDLE with rom_cs=0.
  - One request: grant it. Next cycle the FSM enters GUARD, rom_cs=1, rom_addr is latched from the requester, and rom_obj_sel reflects the grant.
  - Both requests: grant the requester not served last (round-robin).
  - Both requests with no history since reset: the winner is set by OBJ_FIRST; if lhbl=0, object wins instead.
- GUARD state (1 cycle):
  - rom_ok is ignored, because it may belong to the previous address.
  - Watchdog counter is cleared.
  - Move to WAIT.
- WAIT state:
  - On rom_ok=1: register rom_data into the granted requester's data output, pulse its ok for exactly one cycle, drop rom_cs, update last-served, and return to IDLE.
  - A granted requester that issues back-to-back requests is re-arbitrated in IDLE, so the minimum per-access cost is IDLE, GUARD, WAIT = 3 cycles.
- Data outputs hold their last value between ok pulses.
- Abort: if the granted requester's req falls while in GUARD or WAIT, drop rom_cs next cycle, return to IDLE, and pulse no ok. A rom_ok arriving in that same cycle is discarded.
- Watchdog: the counter increments each cycle in WAIT.
  - When the counter reaches TIMEOUT: set timeout, pulse the granted ok with data forced to 16'hFFFF, and return to IDLE. This prevents a fetcher lock-up.
  - The counter saturates; it never wraps.
- rom_addr and rom_obj_sel change only on the IDLE→GUARD transition and are never modified while rom_cs=1.
- Address compare: if the new grant's address equals the previous rom_addr and the same requester is granted, still go through GUARD; do not reuse cached data.
- rst asserted mid-access: all outputs return to reset values on the next clk edge, and the in-flight SDRAM access is abandoned. The SDRAM slot tolerates rom_cs dropping.

Decomposition:
- Shared package (jtlabrun_pkg): state encoding (IDLE, GUARD, WAIT), grant encoding (GNT_TILE=0, GNT_OBJ=1), timeout fill constant 16'hFFFF.
- Keep the watchdog counter and saturate logic in one sub-module, jtlabrun_romarb_wdog (ports: clk, rst, run, clr, expired).

Test Plan:
- Tile only: tile_req=1, tile_addr=17'h00123, rom_ok rises 4 cycles after rom_cs with rom_data=16'hA5A5. Expect rom_addr=17'h00123, rom_obj_sel=0, and one tile_ok pulse with tile_data=16'hA5A5; obj_ok stays 0.
- Simultaneous requests after reset, OBJ_FIRST=0, lhbl=1: tile is served first, then obj is served without re-request. Check rom_obj_sel sequence 0 then 1, and both ok pulses occur exactly once.
- Stale ok: hold rom_ok=1 continuously across a grant change. Expect no ok pulse during the GUARD cycle, and the first ok pulse exactly 2 cycles after the IDLE→GUARD transition.
- Abort: drop obj_req in WAIT while rom_ok rises in the same cycle. Expect obj_ok=0, rom_cs=0 next cycle, state back to IDLE.
- Timeout: tile_req=1 with rom_ok never asserted. Expect tile_ok pulse with tile_data=16'hFFFF after TIMEOUT=63 WAIT cycles and timeout=1 sticky; rst clears it.
- Reset mid-access: assert rst during WAIT. Expect rom_cs=0 and all ok=0 on the next edge, with no ok pulse after rst is released unless a fresh request is made.
